// File: rtl/mario_pkg.sv
// Shared types and constants for the Mario sprite motion controller.
// Included by the horizontal datapath (top) and the vertical state machine.
package mario_pkg;

  localparam int unsigned POS_W       = 10;
  localparam int unsigned VEL_W       = 10;
  localparam int unsigned CALC_W      = POS_W + 1;
  localparam int unsigned KEY_W       = 8;
  localparam int unsigned SPRITE_SIZE = 16;
  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;

  localparam logic [KEY_W-1:0] KEY_A     = 8'h04;
  localparam logic [KEY_W-1:0] KEY_D     = 8'h07;
  localparam logic [KEY_W-1:0] KEY_W_JMP = 8'h1A;
  localparam logic [KEY_W-1:0] KEY_SPACE = 8'h2C;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } mstate_t;

  // W and space both trigger a jump
  function automatic logic is_jump_key(input logic [KEY_W-1:0] key);
    return (key == KEY_W_JMP) || (key == KEY_SPACE);
  endfunction

endpackage

// File: rtl/mario_vert_fsm.sv
// Vertical motion: GROUND/RISE/FALL sequencing with a divided gravity step.
// Owns y, vy, the gravity divider and the jump re-arm latch.
module mario_vert_fsm
  import mario_pkg::*;
#(
  parameter int unsigned Y_MIN     = 0,
  parameter int unsigned Y_FLOOR   = SCREEN_H - SPRITE_SIZE - 1,
  parameter int unsigned JUMP_V    = 8,
  parameter int unsigned GRAV_DIV  = 2,
  parameter int unsigned VMAX_FALL = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    jump_key,
  output logic [POS_W-1:0]        y,
  output logic signed [VEL_W-1:0] vy,
  output logic [1:0]              mstate
);

  localparam int unsigned CNT_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam logic [CNT_W-1:0] GRAV_LAST = CNT_W'(GRAV_DIV - 1);
  localparam logic signed [CALC_W-1:0] Y_MIN_S   = CALC_W'(Y_MIN);
  localparam logic signed [CALC_W-1:0] Y_FLOOR_S = CALC_W'(Y_FLOOR);
  localparam logic signed [VEL_W-1:0]  JUMP_S    = VEL_W'(JUMP_V);
  localparam logic signed [VEL_W-1:0]  VMAX_S    = VEL_W'(VMAX_FALL);

  mstate_t                 state_q, state_d;
  logic [CNT_W-1:0]        grav_cnt_q, grav_cnt_d;
  logic signed [VEL_W-1:0] vy_q, vy_d;
  logic [POS_W-1:0]        y_q, y_d;
  logic                    jump_armed_q, jump_armed_d;

  logic [CNT_W-1:0]         cnt_grav_c;
  logic signed [VEL_W-1:0]  vy_grav_c;
  logic signed [VEL_W-1:0]  vy_fall_c;
  logic signed [CALC_W-1:0] y_rise_c;
  logic signed [CALC_W-1:0] y_fall_c;

  // Gravity step shared by RISE and FALL; FALL additionally saturates vy
  always_comb begin
    cnt_grav_c = grav_cnt_q + CNT_W'(1);
    vy_grav_c  = vy_q;
    if (grav_cnt_q == GRAV_LAST) begin
      cnt_grav_c = '0;
      vy_grav_c  = vy_q + 10'sd1;
    end
    vy_fall_c = (vy_grav_c > VMAX_S) ? VMAX_S : vy_grav_c;
    y_rise_c  = $signed({1'b0, y_q}) + $signed({vy_grav_c[VEL_W-1], vy_grav_c});
    y_fall_c  = $signed({1'b0, y_q}) + $signed({vy_fall_c[VEL_W-1], vy_fall_c});
  end

  // Next-state and vertical position/velocity
  always_comb begin
    state_d      = state_q;
    grav_cnt_d   = grav_cnt_q;
    vy_d         = vy_q;
    y_d          = y_q;
    jump_armed_d = jump_key ? jump_armed_q : 1'b1;

    case (state_q)
      GROUND: begin
        vy_d = '0;
        if (jump_key && jump_armed_q) begin
          state_d      = RISE;
          vy_d         = -JUMP_S;
          y_d          = y_q - POS_W'(JUMP_V);
          grav_cnt_d   = '0;
          jump_armed_d = 1'b0;
        end
      end
      RISE: begin
        if (y_rise_c < Y_MIN_S) begin
          state_d    = FALL;
          y_d        = POS_W'(Y_MIN);
          vy_d       = '0;
          grav_cnt_d = '0;
        end else if (!vy_grav_c[VEL_W-1]) begin
          state_d    = FALL;
          y_d        = y_rise_c[POS_W-1:0];
          vy_d       = vy_grav_c;
          grav_cnt_d = '0;
        end else begin
          y_d        = y_rise_c[POS_W-1:0];
          vy_d       = vy_grav_c;
          grav_cnt_d = cnt_grav_c;
        end
      end
      FALL: begin
        if (y_fall_c >= Y_FLOOR_S) begin
          state_d    = GROUND;
          y_d        = POS_W'(Y_FLOOR);
          vy_d       = '0;
          grav_cnt_d = '0;
        end else begin
          y_d        = y_fall_c[POS_W-1:0];
          vy_d       = vy_fall_c;
          grav_cnt_d = cnt_grav_c;
        end
      end
      default: begin
        state_d    = FALL;
        vy_d       = '0;
        grav_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= GROUND;
      grav_cnt_q   <= '0;
      vy_q         <= '0;
      y_q          <= POS_W'(Y_FLOOR);
      jump_armed_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grav_cnt_q   <= grav_cnt_d;
      vy_q         <= vy_d;
      y_q          <= y_d;
      jump_armed_q <= jump_armed_d;
    end
  end

  assign y      = y_q;
  assign vy     = vy_q;
  assign mstate = state_q;

endmodule

// File: rtl/mario_motion_ctrl.sv
// Per-frame Mario movement: keycode-driven walk with wall clamps on X,
// jump/gravity handled by mario_vert_fsm on Y. Velocities apply with no lag.
module mario_motion_ctrl
  import mario_pkg::*;
#(
  parameter int unsigned X_START   = 320,
  parameter int unsigned X_MIN     = 0,
  parameter int unsigned X_MAX     = SCREEN_W - SPRITE_SIZE - 1,
  parameter int unsigned Y_MIN     = 0,
  parameter int unsigned Y_FLOOR   = SCREEN_H - SPRITE_SIZE - 1,
  parameter int unsigned WALK_V    = 2,
  parameter int unsigned JUMP_V    = 8,
  parameter int unsigned GRAV_DIV  = 2,
  parameter int unsigned VMAX_FALL = 6
) (
  input  logic             frame_clk,
  input  logic             Reset,
  input  logic [KEY_W-1:0] keycode,
  output logic [POS_W-1:0] mario_x,
  output logic [POS_W-1:0] mario_y,
  output logic [VEL_W-1:0] vel_x,
  output logic [VEL_W-1:0] vel_y,
  output logic [1:0]       mstate,
  output logic             facing_left
);

  localparam logic signed [CALC_W-1:0] X_MIN_S = CALC_W'(X_MIN);
  localparam logic signed [CALC_W-1:0] X_MAX_S = CALC_W'(X_MAX);
  localparam logic signed [VEL_W-1:0]  WALK_S  = VEL_W'(WALK_V);

  logic [POS_W-1:0]         x_q, x_d;
  logic signed [VEL_W-1:0]  vel_x_q, vel_x_d;
  logic                     facing_left_q, facing_left_d;
  logic signed [VEL_W-1:0]  vx_c;
  logic signed [CALC_W-1:0] x_sum_c;
  logic                     jump_key_c;
  logic signed [VEL_W-1:0]  vy_w;

  assign jump_key_c = is_jump_key(keycode);

  // Horizontal velocity from the key, then clamp at the screen edges
  always_comb begin
    vx_c          = '0;
    facing_left_d = facing_left_q;
    if (keycode == KEY_A) begin
      vx_c          = -WALK_S;
      facing_left_d = 1'b1;
    end else if (keycode == KEY_D) begin
      vx_c          = WALK_S;
      facing_left_d = 1'b0;
    end

    x_sum_c = $signed({1'b0, x_q}) + $signed({vx_c[VEL_W-1], vx_c});
    x_d     = x_sum_c[POS_W-1:0];
    vel_x_d = vx_c;
    if (x_sum_c < X_MIN_S) begin
      x_d     = POS_W'(X_MIN);
      vel_x_d = '0;
    end else if (x_sum_c > X_MAX_S) begin
      x_d     = POS_W'(X_MAX);
      vel_x_d = '0;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      x_q           <= POS_W'(X_START);
      vel_x_q       <= '0;
      facing_left_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      vel_x_q       <= vel_x_d;
      facing_left_q <= facing_left_d;
    end
  end

  mario_vert_fsm #(
    .Y_MIN     (Y_MIN),
    .Y_FLOOR   (Y_FLOOR),
    .JUMP_V    (JUMP_V),
    .GRAV_DIV  (GRAV_DIV),
    .VMAX_FALL (VMAX_FALL)
  ) u_vert (
    .clk      (frame_clk),
    .rst      (Reset),
    .jump_key (jump_key_c),
    .y        (mario_y),
    .vy       (vy_w),
    .mstate   (mstate)
  );

  assign mario_x     = x_q;
  assign vel_x       = vel_x_q;
  assign vel_y       = vy_w;
  assign facing_left = facing_left_q;

endmodule
